// File: rtl/output_buffer_read_sequencer.sv
// Output buffer read sequencer: sweeps ADC groups through the read-mode buffer,
// packs 4-bit encoder codes eight to a 32-bit word and queues the words in a
// small FIFO drained by the host over valid/ready.
//
// state | meaning
// IDLE  | waiting for start_i
// WR    | drive column address, strobe buf_w_en_o
// RD    | hold address, strobe read_load_en_o, capture enc_i[3:0]
// FULLW | packed word ready but FIFO full; strobes low
// PUSH  | write packed word to FIFO tail
// DONE  | one-cycle done_o pulse
module output_buffer_read_sequencer #(
   parameter int NUM_ADC_MAX = 128,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [7:0]  num_adc_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [8:0]  col_addr9_o,
   output logic        buf_w_en_o,
   output logic        read_load_en_o,
   input  logic [31:0] enc_i,
   output logic [31:0] data_o,
   output logic        valid_o,
   input  logic        ready_i
);

   localparam int          PW    = $clog2(FIFO_DEPTH);
   localparam int          CW    = PW + 1;
   localparam logic [7:0]  N_MAX = 8'(NUM_ADC_MAX);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_RD, S_FULLW, S_PUSH, S_DONE
   } state_t;

   state_t          state, state_nxt;
   logic [7:0]      n_q;
   logic [7:0]      idx;
   logic [2:0]      k;
   logic [31:0]     pack;
   logic [31:0]     mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic            full, push, pop, last_grp, word_done;
   logic [7:0]      n_clamp;
   logic            enc_unused;

   // only the low nibble of the buffer output carries the encoder code
   assign enc_unused = ^enc_i[31:4];

   assign n_clamp   = (num_adc_i > N_MAX) ? N_MAX : num_adc_i;
   assign last_grp  = (idx == n_q - 8'd1);
   assign word_done = (k == 3'd7) || last_grp;
   assign full      = (count == CNT_FULL);
   assign push      = (state == S_PUSH) && !full;
   assign pop       = valid_o && ready_i;

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_i) state_nxt = (n_clamp == 8'd0) ? S_DONE : S_WR;
         S_WR:    state_nxt = S_RD;
         S_RD:    if (word_done) state_nxt = full ? S_FULLW : S_PUSH;
                  else           state_nxt = S_WR;
         S_FULLW: if (!full) state_nxt = S_PUSH;
         S_PUSH:  state_nxt = last_grp ? S_DONE : S_WR;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // output decode; address is only driven while strobing
   always_comb begin
      busy_o         = (state != S_IDLE);
      done_o         = (state == S_DONE);
      buf_w_en_o     = (state == S_WR);
      read_load_en_o = (state == S_RD);
      col_addr9_o    = (buf_w_en_o || read_load_en_o) ? {idx[6:0], 2'b00} : 9'd0;
   end

   // group index, nibble count and packing register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         n_q  <= '0;
         idx  <= '0;
         k    <= '0;
         pack <= '0;
      end else begin
         case (state)
            S_IDLE: if (start_i) begin
               n_q  <= n_clamp;
               idx  <= '0;
               k    <= '0;
               pack <= '0;
            end
            S_RD: begin
               pack[{k, 2'b00} +: 4] <= enc_i[3:0];
               if (!word_done) begin
                  k   <= k + 3'd1;
                  idx <= idx + 8'd1;
               end
            end
            S_PUSH: begin
               pack <= '0;
               k    <= '0;
               if (!last_grp) idx <= idx + 8'd1;
            end
            default: ;
         endcase
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= pack;
   end

   assign valid_o = (count != '0);
   assign data_o  = valid_o ? mem[rd_ptr] : 32'd0;

endmodule
